// File: rtl/nx_host_ctrl.sv
// nx_host_ctrl: host-side initiator for the Nexus control channel (command encode, reply decode, output reassembly).
// Optional read-reply timeout is compiled in when NX_HOST_CTRL_TIMEOUT_EN is defined.
package nx_host_pkg;
  localparam int TIMER_WIDTH      = 32;
  localparam int MAX_COLUMNS      = 8;
  localparam int OUT_BITS_PER_MSG = 128;
  localparam int INDEX_WIDTH      = 8;

  localparam logic [1:0] CMD_READ_PARAMS = 2'd0;
  localparam logic [1:0] CMD_READ_STATUS = 2'd1;
  localparam logic [1:0] CMD_TRIGGER     = 2'd2;
  localparam logic [1:0] CMD_SOFT_RESET  = 2'd3;

  localparam logic [2:0] FMT_PARAMS    = 3'd0;
  localparam logic [2:0] FMT_STATUS    = 3'd1;
  localparam logic [2:0] FMT_OUTPUTS   = 3'd2;
  localparam logic [2:0] FMT_FROM_MESH = 3'd3;

  typedef struct packed {
    logic [1:0]             command;
    logic [TIMER_WIDTH-1:0] cycles;
    logic                   active;
    logic [MAX_COLUMNS-1:0] col_mask;
    logic [4:0]             reserved;
  } control_request_t;

  typedef struct packed {
    logic [2:0]                  format;
    logic [INDEX_WIDTH-1:0]      index;
    logic [TIMER_WIDTH-1:0]      stamp;
    logic [OUT_BITS_PER_MSG-1:0] payload;
  } control_response_t;
endpackage

module nx_host_ctrl
  import nx_host_pkg::*;
#(
  parameter int COLUMNS = 3,
  parameter int OUTPUTS = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_cmd_valid,
  output logic                         o_cmd_ready,
  input  logic [1:0]                   i_cmd_op,
  input  logic [TIMER_WIDTH-1:0]       i_cmd_cycles,
  input  logic                         i_cmd_active,
  input  logic [COLUMNS-1:0]           i_cmd_col_mask,
  output control_request_t             o_ctrl_in_data,
  output logic                         o_ctrl_in_valid,
  input  logic                         i_ctrl_in_ready,
  input  control_response_t            i_ctrl_out_data,
  input  logic                         i_ctrl_out_last,
  input  logic                         i_ctrl_out_valid,
  output logic                         o_ctrl_out_ready,
  output control_response_t            o_rsp_data,
  output logic                         o_rsp_valid,
  output logic [COLUMNS*OUTPUTS-1:0]   o_outputs,
  output logic [TIMER_WIDTH-1:0]       o_outputs_stamp,
  output logic                         o_outputs_valid,
  output logic                         o_busy,
  output logic                         o_timeout
);
  localparam int MESH_OUTPUTS = COLUMNS * OUTPUTS;
  localparam int NUM_SECTIONS = (MESH_OUTPUTS + OUT_BITS_PER_MSG - 1) / OUT_BITS_PER_MSG;
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_SECTIONS - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t            state_reg, state_next;
  control_request_t  req_reg;
  control_response_t rsp_data_reg;
  logic              ready_reg;
  logic              rsp_valid_reg, outputs_valid_reg;
  logic [MESH_OUTPUTS-1:0] outputs_reg;
  logic [TIMER_WIDTH-1:0]  stamp_reg;
  logic [NUM_SECTIONS*OUT_BITS_PER_MSG-1:0] merged;
  logic cmd_accept, rsp_fire, reply_match, timeout_hit;
  logic [2:0] wanted_format;

  assign cmd_accept    = i_cmd_valid && o_cmd_ready;
  assign rsp_fire      = i_ctrl_out_valid && ready_reg;
  assign wanted_format = (req_reg.command == CMD_READ_PARAMS) ? FMT_PARAMS : FMT_STATUS;
  assign reply_match   = (state_reg == WAIT) && rsp_fire && i_ctrl_out_last &&
                         (i_ctrl_out_data.format == wanted_format);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Commands with op[1] set (TRIGGER, SOFT_RESET) expect no reply.
  always_comb begin
    state_next      = state_reg;
    o_cmd_ready     = 1'b0;
    o_ctrl_in_valid = 1'b0;
    o_busy          = 1'b1;
    unique case (state_reg)
      IDLE: begin
        o_busy      = 1'b0;
        o_cmd_ready = ready_reg;
        if (cmd_accept) state_next = SEND;
      end
      SEND: begin
        o_ctrl_in_valid = 1'b1;
        if (i_ctrl_in_ready) state_next = req_reg.command[1] ? IDLE : WAIT;
      end
      WAIT: if (reply_match || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_reg <= '0;
    end else if (cmd_accept) begin
      req_reg.command  <= i_cmd_op;
      req_reg.cycles   <= i_cmd_cycles;
      req_reg.active   <= i_cmd_active;
      req_reg.col_mask <= MAX_COLUMNS'(i_cmd_col_mask);
      req_reg.reserved <= '0;
    end
  end

  for (genvar gi = 0; gi < NUM_SECTIONS; gi++) begin : g_section
    logic [OUT_BITS_PER_MSG-1:0] section_reg;
    logic hit;
    assign hit = rsp_fire && (i_ctrl_out_data.format == FMT_OUTPUTS) &&
                 (i_ctrl_out_data.index == INDEX_WIDTH'(gi));
    // The final section is forwarded in the same cycle it is written.
    assign merged[gi*OUT_BITS_PER_MSG +: OUT_BITS_PER_MSG] = hit ? i_ctrl_out_data.payload : section_reg;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)  section_reg <= '0;
      else if (hit)  section_reg <= i_ctrl_out_data.payload;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ready_reg         <= 1'b0;
      rsp_data_reg      <= '0;
      rsp_valid_reg     <= 1'b0;
      outputs_reg       <= '0;
      stamp_reg         <= '0;
      outputs_valid_reg <= 1'b0;
    end else begin
      ready_reg         <= 1'b1;
      rsp_valid_reg     <= 1'b0;
      outputs_valid_reg <= 1'b0;
      if (rsp_fire) begin
        case (i_ctrl_out_data.format)
          FMT_PARAMS, FMT_STATUS, FMT_FROM_MESH: begin
            rsp_data_reg  <= i_ctrl_out_data;
            rsp_valid_reg <= 1'b1;
          end
          FMT_OUTPUTS: if (i_ctrl_out_data.index == LAST_INDEX) begin
            outputs_reg       <= merged[MESH_OUTPUTS-1:0];
            stamp_reg         <= i_ctrl_out_data.stamp;
            outputs_valid_reg <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef NX_HOST_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             timeout_reg;

  assign timeout_hit = (state_reg == WAIT) && !reply_match && (wait_cnt_reg == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      wait_cnt_reg <= (state_reg == WAIT) ? wait_cnt_reg + 1'b1 : '0;
      if (timeout_hit)                    timeout_reg <= 1'b1;
      else if (cmd_accept && !i_cmd_op[1]) timeout_reg <= 1'b0;
    end
  end
  assign o_timeout = timeout_reg;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign o_timeout      = 1'b0;
`endif

  logic unused_merged;
  assign unused_merged = ^merged;

  assign o_ctrl_in_data   = req_reg;
  assign o_ctrl_out_ready = ready_reg;
  assign o_rsp_data       = rsp_data_reg;
  assign o_rsp_valid      = rsp_valid_reg;
  assign o_outputs        = outputs_reg;
  assign o_outputs_stamp  = stamp_reg;
  assign o_outputs_valid  = outputs_valid_reg;
endmodule

// File: tb/tb_nx_host_ctrl.sv
// Self-checking bench for nx_host_ctrl: directed sequence with randomized fields against a reference model.
`timescale 1ns/1ps
module tb_nx_host_ctrl;
  import nx_host_pkg::*;

  localparam int COLS = 3;
  localparam int OUTS = 32;
  localparam int TMO  = 16;
  localparam int MESH = COLS * OUTS;
  localparam int NSEC = (MESH + OUT_BITS_PER_MSG - 1) / OUT_BITS_PER_MSG;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_active = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [TIMER_WIDTH-1:0] cmd_cycles = '0;
  logic [COLS-1:0] cmd_col_mask = '0;
  control_request_t ctrl_in_data;
  logic ctrl_in_valid, ctrl_in_ready = 1'b0;
  control_response_t ctrl_out_data = '0;
  logic ctrl_out_last = 1'b0, ctrl_out_valid = 1'b0, ctrl_out_ready;
  control_response_t rsp_data;
  logic rsp_valid, outputs_valid, busy, timeout;
  logic [MESH-1:0] outputs;
  logic [TIMER_WIDTH-1:0] outputs_stamp;

  nx_host_ctrl #(.COLUMNS(COLS), .OUTPUTS(OUTS), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
    .i_cmd_cycles(cmd_cycles), .i_cmd_active(cmd_active), .i_cmd_col_mask(cmd_col_mask),
    .o_ctrl_in_data(ctrl_in_data), .o_ctrl_in_valid(ctrl_in_valid), .i_ctrl_in_ready(ctrl_in_ready),
    .i_ctrl_out_data(ctrl_out_data), .i_ctrl_out_last(ctrl_out_last),
    .i_ctrl_out_valid(ctrl_out_valid), .o_ctrl_out_ready(ctrl_out_ready),
    .o_rsp_data(rsp_data), .o_rsp_valid(rsp_valid),
    .o_outputs(outputs), .o_outputs_stamp(outputs_stamp), .o_outputs_valid(outputs_valid),
    .o_busy(busy), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, req_count = 0;
  always @(posedge clk) if (rst_n && ctrl_in_valid && ctrl_in_ready) req_count++;

  // Reference model: section store and the last published vector.
  logic [OUT_BITS_PER_MSG-1:0] model_sec [NSEC];
  logic [MESH-1:0]             exp_outputs = '0;
  logic [TIMER_WIDTH-1:0]      exp_stamp = '0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic control_request_t exp_req(input logic [1:0] op, input logic [31:0] cyc,
                                               input logic act, input logic [COLS-1:0] m);
    control_request_t r;
    r = '0;
    r.command = op;
    r.cycles = cyc;
    r.active = act;
    r.col_mask[COLS-1:0] = m;
    return r;
  endfunction

  function automatic control_response_t mk_rsp(input logic [2:0] fmt, input logic [7:0] idx,
                                               input logic [31:0] st, input logic [127:0] pl);
    control_response_t r;
    r.format = fmt; r.index = idx; r.stamp = st; r.payload = pl;
    return r;
  endfunction

  task automatic model_outputs(input logic [7:0] idx, input logic [31:0] st,
                               input logic [127:0] pl, output logic pulse);
    logic [NSEC*OUT_BITS_PER_MSG-1:0] flat;
    pulse = 1'b0;
    if (int'(idx) < NSEC) model_sec[idx] = pl;
    if (int'(idx) == NSEC - 1) begin
      for (int s = 0; s < NSEC; s++) flat[s*OUT_BITS_PER_MSG +: OUT_BITS_PER_MSG] = model_sec[s];
      exp_outputs = flat[MESH-1:0];
      exp_stamp = st;
      pulse = 1'b1;
    end
  endtask

  task automatic put_cmd(input logic [1:0] op, input logic [31:0] cyc, input logic act, input logic [COLS-1:0] m);
    cmd_valid = 1'b1; cmd_op = op; cmd_cycles = cyc; cmd_active = act; cmd_col_mask = m;
  endtask

  initial begin
    control_request_t  er;
    control_response_t r1, r2;
    logic pulse;
    logic [7:0] idx;
    logic [31:0] st;
    logic [127:0] pl;
    for (int s = 0; s < NSEC; s++) model_sec[s] = '0;

    // Reset state
    #2;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_in_valid", ctrl_in_valid, 0);
    chk("rst_outputs", outputs, 0);
    step(); rst_n = 1'b1; step(); step();
    chk("rel_cmd_ready", cmd_ready, 1);
    chk("rel_out_ready", ctrl_out_ready, 1);
    chk("rel_busy", busy, 0);
    $display("txn reset released");

    // READ_PARAMS with back-pressure on the request
    er = exp_req(CMD_READ_PARAMS, $urandom, 1'b0, COLS'($urandom));
    put_cmd(er.command, er.cycles, er.active, er.col_mask[COLS-1:0]);
    step(); cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rp_valid_held", ctrl_in_valid, 1);
      chk("rp_data_stable", ctrl_in_data, er);
      step();
    end
    ctrl_in_ready = 1'b1; step(); ctrl_in_ready = 1'b0;
    chk("rp_one_request", req_count, 1);
    chk("rp_wait_busy", busy, 1);
    r1 = mk_rsp(FMT_PARAMS, 8'd0, $urandom, {$urandom, $urandom, $urandom, $urandom});
    ctrl_out_data = r1; ctrl_out_last = 1'b1; ctrl_out_valid = 1'b1;
    step(); ctrl_out_valid = 1'b0;
    chk("rp_rsp_valid", rsp_valid, 1);
    chk("rp_rsp_data", rsp_data, r1);
    chk("rp_idle", busy, 0);
    step();
    chk("rp_rsp_once", rsp_valid, 0);
    $display("txn READ_PARAMS done");

    // TRIGGER / SOFT_RESET, first one directed, rest randomized
    ctrl_in_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) er = exp_req(CMD_TRIGGER, 32'd5, 1'b1, 3'b101);
      else er = exp_req(($urandom & 1) ? CMD_TRIGGER : CMD_SOFT_RESET, $urandom, 1'($urandom), COLS'($urandom));
      put_cmd(er.command, er.cycles, er.active, er.col_mask[COLS-1:0]);
      step(); cmd_valid = 1'b0;
      chk("trig_valid", ctrl_in_valid, 1);
      chk("trig_data", ctrl_in_data, er);
      step();
      chk("trig_idle", busy, 0);
      chk("trig_cmd_ready", cmd_ready, 1);
      $display("txn cmd op=%0d cycles=%0d active=%0d mask=%0b", er.command, er.cycles, er.active, er.col_mask);
    end
    ctrl_in_ready = 1'b0;

    // OUTPUTS: directed index 0 then 1, then random indices and a dropped format
    for (int i = 0; i < 10; i++) begin
      idx = (i == 0) ? 8'd0 : (i == 1) ? 8'd1 : 8'($urandom_range(0, 2));
      st  = (i == 0) ? 32'd7 : $urandom;
      pl  = {$urandom, $urandom, $urandom, $urandom};
      ctrl_out_data = mk_rsp((i == 9) ? 3'd5 : FMT_OUTPUTS, idx, st, pl);
      ctrl_out_last = 1'b1; ctrl_out_valid = 1'b1;
      if (i == 9) pulse = 1'b0;
      else model_outputs(idx, st, pl, pulse);
      step(); ctrl_out_valid = 1'b0;
      chk("out_pulse", outputs_valid, pulse);
      chk("out_vector", outputs, exp_outputs);
      chk("out_stamp", outputs_stamp, exp_stamp);
      chk("out_no_rsp", rsp_valid, 0);
      step();
      chk("out_pulse_end", outputs_valid, 0);
      $display("txn outputs idx=%0d stamp=%0d pulse=%0d", idx, st, pulse);
    end

    // READ_STATUS answered by FROM_MESH then STATUS
    ctrl_in_ready = 1'b1;
    put_cmd(CMD_READ_STATUS, 32'd0, 1'b0, '0);
    step(); cmd_valid = 1'b0;
    chk("rs_valid", ctrl_in_valid, 1);
    step(); ctrl_in_ready = 1'b0;
    chk("rs_wait", busy, 1);
    r1 = mk_rsp(FMT_FROM_MESH, 8'($urandom), $urandom, {$urandom, $urandom, $urandom, $urandom});
    r2 = mk_rsp(FMT_STATUS, 8'd0, $urandom, {$urandom, $urandom, $urandom, $urandom});
    ctrl_out_data = r1; ctrl_out_last = 1'b1; ctrl_out_valid = 1'b1;
    step();
    chk("rs_mesh_valid", rsp_valid, 1);
    chk("rs_mesh_data", rsp_data, r1);
    chk("rs_still_wait", busy, 1);
    ctrl_out_data = r2;
    step(); ctrl_out_valid = 1'b0;
    chk("rs_status_valid", rsp_valid, 1);
    chk("rs_status_data", rsp_data, r2);
    chk("rs_idle", busy, 0);
    $display("txn READ_STATUS done");

    // Read with no reply
    ctrl_in_ready = 1'b1;
    put_cmd(CMD_READ_STATUS, 32'd0, 1'b0, '0);
    step(); cmd_valid = 1'b0;
    step(); ctrl_in_ready = 1'b0;
`ifdef NX_HOST_CTRL_TIMEOUT_EN
    for (int i = 0; i < TMO - 1; i++) step();
    chk("to_before", busy, 1);
    chk("to_flag_before", timeout, 0);
    step();
    chk("to_idle", busy, 0);
    chk("to_flag", timeout, 1);
    ctrl_in_ready = 1'b1;
    put_cmd(CMD_READ_PARAMS, 32'd0, 1'b0, '0);
    step(); cmd_valid = 1'b0;
    chk("to_cleared", timeout, 0);
    step(); ctrl_in_ready = 1'b0;
    ctrl_out_data = mk_rsp(FMT_PARAMS, 8'd0, 32'd0, '0);
`else
    for (int i = 0; i < 20; i++) step();
    chk("nto_busy", busy, 1);
    chk("nto_flag", timeout, 0);
    ctrl_out_data = mk_rsp(FMT_STATUS, 8'd0, 32'd0, '0);
`endif
    ctrl_out_last = 1'b1; ctrl_out_valid = 1'b1;
    step(); ctrl_out_valid = 1'b0;
    chk("nr_idle", busy, 0);
    $display("txn unanswered read done");

    // Command accept and OUTPUTS response in the same cycle
    ctrl_in_ready = 1'b1;
    er = exp_req(CMD_TRIGGER, $urandom, 1'b1, COLS'($urandom));
    put_cmd(er.command, er.cycles, er.active, er.col_mask[COLS-1:0]);
    st = $urandom; pl = {$urandom, $urandom, $urandom, $urandom};
    ctrl_out_data = mk_rsp(FMT_OUTPUTS, 8'(NSEC - 1), st, pl); ctrl_out_valid = 1'b1;
    model_outputs(8'(NSEC - 1), st, pl, pulse);
    step(); cmd_valid = 1'b0; ctrl_out_valid = 1'b0;
    chk("sim_req", ctrl_in_data, er);
    chk("sim_pulse", outputs_valid, pulse);
    chk("sim_vector", outputs, exp_outputs);
    step();
    chk("sim_idle", busy, 0);
    $display("txn simultaneous cmd+outputs done");

    // Asynchronous reset while in SEND
    ctrl_in_ready = 1'b0;
    put_cmd(CMD_TRIGGER, 32'd9, 1'b1, '1);
    step(); cmd_valid = 1'b0;
    chk("ar_send", ctrl_in_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid_drop", ctrl_in_valid, 0);
    chk("ar_outputs", outputs, 0);
    step(); rst_n = 1'b1; step(); step();
    chk("ar_busy", busy, 0);
    chk("ar_cmd_ready", cmd_ready, 1);
    chk("ar_stamp", outputs_stamp, 0);
    $display("txn async reset done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nx_host_ctrl.md
Name: nx_host_ctrl

Overview:
- Host-side initiator for the Nexus control channel.
- Accepts simple host commands and encodes them as control_request_t messages towards the controller.
- Consumes the returned control_response_t stream: decodes replies, reassembles output-section messages into a full mesh output vector, and forwards mesh messages.
- Sits between the host bus adapter and the top-level controller.

Parameters:
- COLUMNS, 3, mesh columns.
- OUTPUTS, 32, outputs per column; MESH_OUTPUTS = COLUMNS*OUTPUTS; NUM_SECTIONS = ceil(MESH_OUTPUTS/OUT_BITS_PER_MSG).
- TIMEOUT, 1024, cycles to wait for a read reply (optional feature only).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_cmd_valid  in  1  host command valid
- o_cmd_ready  out  1  command accepted when high with i_cmd_valid
- i_cmd_op  in  2  0 READ_PARAMS, 1 READ_STATUS, 2 TRIGGER, 3 SOFT_RESET
- i_cmd_cycles  in  TIMER_WIDTH  trigger interval
- i_cmd_active  in  1  trigger active flag
- i_cmd_col_mask  in  COLUMNS  trigger column mask
- o_ctrl_in_data  out  control_request_t  request to controller
- o_ctrl_in_valid  out  1  request valid
- i_ctrl_in_ready  in  1  request ready
- i_ctrl_out_data  in  control_response_t  response from controller
- i_ctrl_out_last  in  1  response last flag
- i_ctrl_out_valid  in  1  response valid
- o_ctrl_out_ready  out  1  response ready
- o_rsp_data  out  control_response_t  captured PARAMS/STATUS/FROM_MESH response
- o_rsp_valid  out  1  one-cycle pulse per captured response
- o_outputs  out  MESH_OUTPUTS  last complete output vector
- o_outputs_stamp  out  TIMER_WIDTH  stamp of o_outputs
- o_outputs_valid  out  1  one-cycle pulse when o_outputs updates
- o_busy  out  1  FSM not IDLE
- o_timeout  out  1  sticky read-timeout flag

Behaviour:
- Reset values: all outputs 0, except o_cmd_ready = 1 and o_ctrl_out_ready = 1 once reset is released. The internal section buffer clears to 0.
- FSM states: IDLE, SEND, WAIT.
- IDLE:
  - o_cmd_ready = 1.
  - On accept, register the command, build the request and go to SEND.
  - The request fields are: command type from op; trigger.cycles, trigger.active, trigger.col_mask (zero-extended); all other bits 0.
- SEND:
  - o_ctrl_in_valid = 1 with stable data until i_ctrl_in_ready.
  - Once the handshake completes: READ_PARAMS and READ_STATUS go to WAIT; TRIGGER and SOFT_RESET go to IDLE.
  - Request valid is registered, so there is no combinational ready-to-valid path.
- WAIT:
  - Leave for IDLE on the first response whose format matches the request (PARAMS or STATUS) and has last = 1.
  - Non-matching responses received in WAIT are still processed by the response path below.
- Response path: o_ctrl_out_ready is held at 1 and never stalls. Each handshake is decoded by format:
  - PARAMS, STATUS, FROM_MESH: register into o_rsp_data and pulse o_rsp_valid on the following cycle.
  - OUTPUTS:
    - Write section into buffer[index] when index < NUM_SECTIONS; ignore index >= NUM_SECTIONS.
    - When index == NUM_SECTIONS-1: copy buffer, with the incoming section merged, to o_outputs (bits beyond MESH_OUTPUTS dropped), set o_outputs_stamp = stamp, and pulse o_outputs_valid.
    - Latency is 1 cycle from the handshake.
  - Any other format: dropped, no pulse.
- Simultaneous command accept and response are independent and must both be processed.
- A SOFT_RESET command affects only the far end. This block returns to IDLE and keeps its buffer.
- Asynchronous reset mid-transfer aborts immediately; all state goes to its reset value.

Optional Feature:
- Macro NX_HOST_CTRL_TIMEOUT_EN.
- Defined:
  - A counter loads 0 on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT-1 without a matching reply, the FSM returns to IDLE and o_timeout sets.
  - o_timeout is sticky until reset or the next accepted READ command.
- Undefined: WAIT is unbounded, no counter is instantiated, and o_timeout is tied to 0.

Test Plan:
- READ_PARAMS with i_ctrl_in_ready low for 3 cycles:
  - Valid held and data stable throughout; one request issued.
  - PARAMS response with last=1 -> o_rsp_valid pulses once, o_busy falls, FSM returns to IDLE.
- TRIGGER cycles=5, active=1, col_mask=3'b101 -> request fields match exactly; FSM returns to IDLE without waiting.
- COLUMNS=3/OUTPUTS=32 (single section):
  - OUTPUTS index=0, stamp=7 -> o_outputs_valid pulse one cycle later, stamp=7, o_outputs equals the low 96 bits.
  - Then index=1 -> ignored, no pulse.
- READ_STATUS with FROM_MESH then STATUS(last=1) replies -> two o_rsp_valid pulses in order; FSM leaves WAIT only after STATUS.
- With NX_HOST_CTRL_TIMEOUT_EN, TIMEOUT=16, READ_STATUS and no reply -> FSM returns to IDLE after 16 WAIT cycles, o_timeout=1; next READ clears it.
- Assert i_rst_n low during SEND -> o_ctrl_in_valid=0 asynchronously; after release, o_busy=0 and o_cmd_ready=1.
